// File: rtl/sd_req_arbiter_pkg.sv
// Shared types and helpers for the multi-drive SD block-request arbiter.
package sd_arb_pkg;

  localparam int MAX_DRIVES = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_XFER  = 2'd2
  } sd_arb_state_e;

  // Index width for a vector of n entries, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 32'sd1;
    while ((32'sd1 << r) < n) begin
      r = r + 32'sd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sd_req_arbiter_if.sv
// Drive-side bundle between the disk controllers / hps_io and the SD request arbiter.
interface sd_req_arbiter_if
  import sd_arb_pkg::*;
#(
  parameter int NUM_DRIVES = 2
) ();

  localparam int AW = clog2_min1(NUM_DRIVES);

  logic [NUM_DRIVES-1:0] req_rd;
  logic [NUM_DRIVES-1:0] req_wr;
  logic [NUM_DRIVES-1:0] img_mounted;
  logic                  img_size_nz;
  logic                  img_readonly;
  logic [NUM_DRIVES-1:0] sd_ack;
  logic [NUM_DRIVES-1:0] sd_rd;
  logic [NUM_DRIVES-1:0] sd_wr;
  logic [NUM_DRIVES-1:0] mounted;
  logic [NUM_DRIVES-1:0] protect;
  logic                  cpu_wait;
  logic [AW-1:0]         active_drv;
  logic                  wr_reject;
  logic [NUM_DRIVES-1:0] err;

  modport slave (
    input  req_rd, req_wr, img_mounted, img_size_nz, img_readonly, sd_ack,
    output sd_rd, sd_wr, mounted, protect, cpu_wait, active_drv, wr_reject, err
  );

  modport master (
    output req_rd, req_wr, img_mounted, img_size_nz, img_readonly, sd_ack,
    input  sd_rd, sd_wr, mounted, protect, cpu_wait, active_drv, wr_reject, err
  );

endinterface

// File: rtl/sd_req_arbiter_rr_pick.sv
// Combinational round-robin picker: first pending drive strictly after the pointer, wrapping.
module sd_rr_pick
  import sd_arb_pkg::*;
#(
  parameter int NUM_DRIVES = 2,
  localparam int AW = clog2_min1(NUM_DRIVES)
) (
  input  logic [NUM_DRIVES-1:0] i_pending,
  input  logic [AW-1:0]         i_ptr,
  output logic [AW-1:0]         o_grant,
  output logic                  o_valid
);

  int w_idx;

  // Scan pointer+1 .. pointer+NUM_DRIVES; the first hit is the grant.
  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    w_idx   = 0;
    for (int k = 1; k <= NUM_DRIVES; k++) begin
      w_idx = (int'(i_ptr) + k) % NUM_DRIVES;
      if (!o_valid && i_pending[w_idx]) begin
        o_valid = 1'b1;
        o_grant = AW'(w_idx);
      end else begin
        o_valid = o_valid;
      end
    end
  end

endmodule

// File: rtl/sd_req_arbiter.sv
// Multi-drive SD block-request arbiter: round-robin grant, sd_ack handshake, mount/protect state.
// Optional per-transfer abort timer enabled by defining SD_ARB_TIMEOUT_EN.
module sd_req_arbiter
  import sd_arb_pkg::*;
#(
  parameter int NUM_DRIVES     = 2,
  parameter int TIMEOUT_CYCLES = 33554432
) (
  input  logic             clk_vid,
  input  logic             reset,
  sd_req_arbiter_if.slave  bus
);

  localparam int AW = clog2_min1(NUM_DRIVES);
  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_ISSUE = ST_ISSUE;
  localparam logic [1:0] S_XFER  = ST_XFER;

  if (NUM_DRIVES < 1 || NUM_DRIVES > MAX_DRIVES || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("sd_req_arbiter: illegal NUM_DRIVES or TIMEOUT_CYCLES");
  end

  logic [1:0]            r_state;
  logic [NUM_DRIVES-1:0] r_rd_pend, r_wr_pend, r_sd_rd, r_sd_wr, r_ack_q;
  logic [NUM_DRIVES-1:0] r_mounted, r_protect, r_err;
  logic [AW-1:0]         r_ptr, r_active;
  logic                  r_cpu_wait, r_wr_reject;

  logic [1:0]            w_state;
  logic [NUM_DRIVES-1:0] w_rd_ok, w_wr_ok, w_clr_rd, w_clr_wr, w_sd_rd, w_sd_wr;
  logic [AW-1:0]         w_pick, w_ptr, w_active;
  logic                  w_pick_valid, w_wr_bad, w_cpu_wait, w_timeout;

  sd_rr_pick #(.NUM_DRIVES(NUM_DRIVES)) u_pick (
    .i_pending (r_rd_pend | r_wr_pend),
    .i_ptr     (r_ptr),
    .o_grant   (w_pick),
    .o_valid   (w_pick_valid)
  );

  // Request qualification and the grant/handshake state machine.
  always_comb begin
    w_rd_ok    = bus.req_rd & r_mounted;
    w_wr_ok    = bus.req_wr & r_mounted & ~r_protect;
    w_wr_bad   = |(bus.req_wr & ~(r_mounted & ~r_protect));
    w_clr_rd   = '0;
    w_clr_wr   = '0;
    w_state    = r_state;
    w_sd_rd    = r_sd_rd;
    w_sd_wr    = r_sd_wr;
    w_cpu_wait = r_cpu_wait;
    w_active   = r_active;
    w_ptr      = r_ptr;
    case (r_state)
      S_IDLE: begin
        if (w_pick_valid) begin
          w_sd_rd = '0;
          w_sd_wr = '0;
          // Read wins when a drive has both directions pending.
          if (r_rd_pend[w_pick]) begin
            w_sd_rd[w_pick] = 1'b1;
          end else begin
            w_sd_wr[w_pick] = 1'b1;
          end
          w_active   = w_pick;
          w_ptr      = w_pick;
          w_cpu_wait = 1'b1;
          w_state    = S_ISSUE;
        end else begin
          w_state = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (w_timeout) begin
          w_sd_rd = '0;
          w_sd_wr = '0;
          w_clr_rd[r_active] = 1'b1;
          w_clr_wr[r_active] = 1'b1;
          w_cpu_wait = 1'b0;
          w_state    = S_IDLE;
        end else if (bus.sd_ack[r_active] && !r_ack_q[r_active]) begin
          w_clr_rd[r_active] = r_sd_rd[r_active];
          w_clr_wr[r_active] = r_sd_wr[r_active];
          w_sd_rd = '0;
          w_sd_wr = '0;
          w_state = S_XFER;
        end else begin
          w_state = S_ISSUE;
        end
      end
      S_XFER: begin
        if (w_timeout) begin
          w_clr_rd[r_active] = 1'b1;
          w_clr_wr[r_active] = 1'b1;
          w_cpu_wait = 1'b0;
          w_state    = S_IDLE;
        end else if (!bus.sd_ack[r_active] && r_ack_q[r_active]) begin
          w_cpu_wait = 1'b0;
          w_state    = S_IDLE;
        end else begin
          w_state = S_XFER;
        end
      end
      default: begin
        w_sd_rd    = '0;
        w_sd_wr    = '0;
        w_cpu_wait = 1'b0;
        w_state    = S_IDLE;
      end
    endcase
  end

  // Arbiter state; a request in the same cycle as its clear keeps the pending bit set.
  always_ff @(posedge clk_vid) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_rd_pend   <= '0;
      r_wr_pend   <= '0;
      r_sd_rd     <= '0;
      r_sd_wr     <= '0;
      r_ack_q     <= '0;
      r_ptr       <= AW'(NUM_DRIVES - 1);
      r_active    <= '0;
      r_cpu_wait  <= 1'b0;
      r_wr_reject <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_rd_pend   <= (r_rd_pend & ~w_clr_rd) | w_rd_ok;
      r_wr_pend   <= (r_wr_pend & ~w_clr_wr) | w_wr_ok;
      r_sd_rd     <= w_sd_rd;
      r_sd_wr     <= w_sd_wr;
      r_ack_q     <= bus.sd_ack;
      r_ptr       <= w_ptr;
      r_active    <= w_active;
      r_cpu_wait  <= w_cpu_wait;
      r_wr_reject <= w_wr_bad;
    end
  end

  // Mount state survives reset so a core reset does not eject images.
  always_ff @(posedge clk_vid) begin
    for (int i = 0; i < NUM_DRIVES; i++) begin
      if (bus.img_mounted[i]) begin
        r_mounted[i] <= bus.img_size_nz;
        r_protect[i] <= bus.img_readonly;
      end else begin
        r_mounted[i] <= r_mounted[i];
        r_protect[i] <= r_protect[i];
      end
    end
  end

`ifdef SD_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] r_cnt;

  assign w_timeout = (r_state != S_IDLE) && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Transfer age counter; zero while idle so it starts from zero on entry to ISSUE.
  always_ff @(posedge clk_vid) begin
    if (reset || (r_state == S_IDLE)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Sticky timeout flag, cleared by the next accepted request to that drive.
  always_ff @(posedge clk_vid) begin
    if (reset) begin
      r_err <= '0;
    end else if (w_timeout) begin
      r_err <= (r_err & ~(w_rd_ok | w_wr_ok)) | (NUM_DRIVES'(1) << r_active);
    end else begin
      r_err <= r_err & ~(w_rd_ok | w_wr_ok);
    end
  end
`else
  assign w_timeout = 1'b0;
  assign r_err     = '0;
`endif

  assign bus.sd_rd      = r_sd_rd;
  assign bus.sd_wr      = r_sd_wr;
  assign bus.mounted    = r_mounted;
  assign bus.protect    = r_protect;
  assign bus.cpu_wait   = r_cpu_wait;
  assign bus.active_drv = r_active;
  assign bus.wr_reject  = r_wr_reject;
  assign bus.err        = r_err;

endmodule

// File: tb/tb_sd_req_arbiter.sv
// Scoreboard bench for sd_req_arbiter (4 drives): expected grants queued at stimulus, compared per grant.
module tb_sd_req_arbiter;

  logic clk_vid = 1'b0;
  logic reset   = 1'b1;
  int   tests   = 0;
  int   failed  = 0;
  int   exp_q[$];
  int   obs_q[$];
  logic [3:0] prev_strobe = 4'b0;

  sd_req_arbiter_if #(.NUM_DRIVES(4)) bus ();

  sd_req_arbiter #(.NUM_DRIVES(4), .TIMEOUT_CYCLES(16)) dut (
    .clk_vid (clk_vid),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk_vid = ~clk_vid;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  // Grant monitor: records each new strobe as drive*2+is_wr and checks one-hotness.
  always @(negedge clk_vid) begin
    logic [3:0] s;
    s = bus.sd_rd | bus.sd_wr;
    if (!reset && s != 4'b0) begin
      tests++;
      if ($countones(s) != 1) begin
        failed++;
        $display("FAIL onehot: sd_rd=%b sd_wr=%b, required at most one bit set", bus.sd_rd, bus.sd_wr);
      end
      if (prev_strobe == 4'b0) begin
        for (int i = 0; i < 4; i++)
          if (s[i]) obs_q.push_back(i * 2 + (bus.sd_wr[i] ? 1 : 0));
      end
    end
    prev_strobe = reset ? 4'b0 : s;
  end

  task automatic tick();
    @(posedge clk_vid);
    #1;
  endtask

  task automatic mount(input logic [3:0] drv, input logic nz, input logic ro);
    bus.img_mounted = drv; bus.img_size_nz = nz; bus.img_readonly = ro;
    tick();
    bus.img_mounted = 4'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
  endtask

  // Waits for a strobe, acks it after two cycles (optionally requesting in the clear cycle), then drops ack.
  task automatic serve_one(input logic [3:0] inject_rd, output bit timed_out);
    int n = 0;
    int g;
    timed_out = 1'b0;
    while (((bus.sd_rd | bus.sd_wr) == 4'b0) && n < 20) begin tick(); n++; end
    if ((bus.sd_rd | bus.sd_wr) == 4'b0) begin
      timed_out = 1'b1;
    end else begin
      g = int'(bus.active_drv);
      tick(); tick();
      bus.sd_ack[g] = 1'b1; bus.req_rd = inject_rd;
      tick();
      bus.req_rd = 4'b0;
      tick();
      bus.sd_ack[g] = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(); tick();
    tests++; if (bus.sd_rd !== 4'b0) begin failed++; $display("FAIL reset_sd_rd: got %b, required 0000", bus.sd_rd); end
    tests++; if (bus.sd_wr !== 4'b0) begin failed++; $display("FAIL reset_sd_wr: got %b, required 0000", bus.sd_wr); end
    tests++; if (bus.cpu_wait !== 1'b0) begin failed++; $display("FAIL reset_cpu_wait: got %b, required 0", bus.cpu_wait); end
    tests++; if (bus.active_drv !== 2'd0) begin failed++; $display("FAIL reset_active: got %0d, required 0", bus.active_drv); end
    tests++; if (bus.wr_reject !== 1'b0 || bus.err !== 4'b0) begin failed++; $display("FAIL reset_rej_err: got %b/%b, required 0/0000", bus.wr_reject, bus.err); end
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    int o;
    mount(4'b0010, 1'b1, 1'b0);
    exp_q.push_back(1 * 2 + 0);
    bus.req_rd = 4'b0010; tick(); bus.req_rd = 4'b0;
    tests++; if (bus.sd_rd !== 4'b0) begin failed++; $display("FAIL sr_early: sd_rd=%b after 1 edge, required 0000", bus.sd_rd); end
    tick();
    tests++; if (bus.sd_rd !== 4'b0010 || bus.cpu_wait !== 1'b1) begin failed++; $display("FAIL sr_strobe: sd_rd=%b wait=%b, required 0010/1", bus.sd_rd, bus.cpu_wait); end
    tests++; if (bus.active_drv !== 2'd1) begin failed++; $display("FAIL sr_active: got %0d, required 1", bus.active_drv); end
    tick(); tick(); tick();
    bus.sd_ack[1] = 1'b1; tick();
    tests++; if (bus.sd_rd !== 4'b0 || bus.cpu_wait !== 1'b1) begin failed++; $display("FAIL sr_ack_hi: sd_rd=%b wait=%b, required 0000/1", bus.sd_rd, bus.cpu_wait); end
    tick(); bus.sd_ack[1] = 1'b0; tick();
    tests++; if (bus.cpu_wait !== 1'b0) begin failed++; $display("FAIL sr_ack_lo: wait=%b, required 0", bus.cpu_wait); end
    o = exp_q.pop_front();
    tests++;
    if (obs_q.size() == 0) begin failed++; $display("FAIL sr_grant: grant queue empty, required %0d", o); end
    else if (obs_q[0] !== o) begin failed++; $display("FAIL sr_grant: got %0d, required %0d", obs_q.pop_front(), o); end
    else void'(obs_q.pop_front());
  endtask

  task automatic test_round_robin();
    bit to;
    int e;
    pulse_reset();
    mount(4'b1111, 1'b1, 1'b0);
    exp_q.push_back(0); exp_q.push_back(4); exp_q.push_back(0);
    bus.req_rd = 4'b0101; tick(); bus.req_rd = 4'b0;
    serve_one(4'b0001, to);
    tests++; if (to) begin failed++; $display("FAIL rr_wait1: no strobe, required grant"); end
    tests++; if (bus.cpu_wait !== 1'b0) begin failed++; $display("FAIL rr_gap: wait=%b between transfers, required 0", bus.cpu_wait); end
    for (int k = 0; k < 2; k++) begin
      serve_one(4'b0, to);
      tests++; if (to) begin failed++; $display("FAIL rr_wait%0d: no strobe, required grant", k + 2); end
    end
    for (int k = 0; k < 3; k++) begin
      e = exp_q.pop_front();
      tests++;
      if (obs_q.size() == 0) begin failed++; $display("FAIL rr_order%0d: grant queue empty, required %0d", k, e); end
      else if (obs_q[0] !== e) begin failed++; $display("FAIL rr_order%0d: got %0d, required %0d", k, obs_q.pop_front(), e); end
      else void'(obs_q.pop_front());
    end
  endtask

  task automatic test_protection();
    mount(4'b0001, 1'b1, 1'b1);
    bus.req_wr = 4'b0001; tick(); bus.req_wr = 4'b0;
    tests++; if (bus.wr_reject !== 1'b1) begin failed++; $display("FAIL prot_reject: got %b, required 1", bus.wr_reject); end
    tick();
    tests++; if (bus.wr_reject !== 1'b0) begin failed++; $display("FAIL prot_pulse: got %b, required 0", bus.wr_reject); end
    tick(); tick();
    tests++; if (bus.sd_wr !== 4'b0 || bus.cpu_wait !== 1'b0) begin failed++; $display("FAIL prot_idle: sd_wr=%b wait=%b, required 0000/0", bus.sd_wr, bus.cpu_wait); end
    tests++; if (bus.protect[0] !== 1'b1) begin failed++; $display("FAIL prot_flag: got %b, required 1", bus.protect[0]); end
  endtask

  task automatic test_rd_wr_same();
    bit to;
    int e;
    mount(4'b0001, 1'b1, 1'b0);
    exp_q.push_back(0); exp_q.push_back(1);
    bus.req_rd = 4'b0001; bus.req_wr = 4'b0001; tick(); bus.req_rd = 4'b0; bus.req_wr = 4'b0;
    tests++; if (bus.wr_reject !== 1'b0) begin failed++; $display("FAIL rw_reject: got %b, required 0", bus.wr_reject); end
    for (int k = 0; k < 2; k++) begin
      serve_one(4'b0, to);
      tests++; if (to) begin failed++; $display("FAIL rw_wait%0d: no strobe, required grant", k); end
      e = exp_q.pop_front();
      tests++;
      if (obs_q.size() == 0) begin failed++; $display("FAIL rw_order%0d: grant queue empty, required %0d", k, e); end
      else if (obs_q[0] !== e) begin failed++; $display("FAIL rw_order%0d: got %0d, required %0d", k, obs_q.pop_front(), e); end
      else void'(obs_q.pop_front());
    end
  endtask

  task automatic test_reset_mid();
    int e;
    int n = 0;
    exp_q.push_back(2 * 2);
    bus.req_rd = 4'b0100; tick(); bus.req_rd = 4'b0;
    while (bus.sd_rd == 4'b0 && n < 20) begin tick(); n++; end
    tests++; if (bus.sd_rd !== 4'b0100) begin failed++; $display("FAIL rm_strobe: sd_rd=%b, required 0100", bus.sd_rd); end
    bus.sd_ack[2] = 1'b1; tick();
    reset = 1'b1; tick();
    tests++; if (bus.sd_rd !== 4'b0 || bus.cpu_wait !== 1'b0) begin failed++; $display("FAIL rm_drop: sd_rd=%b wait=%b, required 0000/0", bus.sd_rd, bus.cpu_wait); end
    reset = 1'b0;
    bus.sd_ack[2] = 1'b0; tick(); bus.sd_ack[2] = 1'b1; tick(); bus.sd_ack[2] = 1'b0; tick(); tick();
    tests++; if ((bus.sd_rd | bus.sd_wr) !== 4'b0 || bus.cpu_wait !== 1'b0) begin failed++; $display("FAIL rm_late_ack: strobe=%b wait=%b, required 0000/0", bus.sd_rd | bus.sd_wr, bus.cpu_wait); end
    tests++; if (bus.mounted !== 4'b1111) begin failed++; $display("FAIL rm_mount: got %b, required 1111", bus.mounted); end
    e = exp_q.pop_front();
    tests++;
    if (obs_q.size() == 0) begin failed++; $display("FAIL rm_grant: grant queue empty, required %0d", e); end
    else if (obs_q[0] !== e) begin failed++; $display("FAIL rm_grant: got %0d, required %0d", obs_q.pop_front(), e); end
    else void'(obs_q.pop_front());
    tests++; if (obs_q.size() != 0) begin failed++; $display("FAIL rm_extra: %0d extra grants, required 0", obs_q.size()); end
  endtask

`ifdef SD_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int hi = 0;
    bit to;
    exp_q.push_back(0); exp_q.push_back(0);
    bus.req_rd = 4'b0001; tick(); bus.req_rd = 4'b0;
    tick();
    while (bus.sd_rd[0] && hi < 40) begin hi++; tick(); end
    tests++; if (hi != 16) begin failed++; $display("FAIL to_len: strobe high %0d cycles, required 16", hi); end
    tests++; if (bus.err[0] !== 1'b1 || bus.cpu_wait !== 1'b0) begin failed++; $display("FAIL to_err: err=%b wait=%b, required 1/0", bus.err[0], bus.cpu_wait); end
    bus.req_rd = 4'b0001; tick(); bus.req_rd = 4'b0;
    tests++; if (bus.err[0] !== 1'b0) begin failed++; $display("FAIL to_clear: err=%b, required 0", bus.err[0]); end
    serve_one(4'b0, to);
    tests++; if (to) begin failed++; $display("FAIL to_retry: no strobe, required grant"); end
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (obs_q.size() == 0) begin failed++; $display("FAIL to_grant%0d: grant queue empty, required 0", k); end
      else if (obs_q[0] !== exp_q[0]) begin failed++; $display("FAIL to_grant%0d: got %0d, required %0d", k, obs_q.pop_front(), exp_q[0]); end
      else void'(obs_q.pop_front());
      void'(exp_q.pop_front());
    end
  endtask
`endif

  initial begin
    bus.req_rd = 4'b0; bus.req_wr = 4'b0; bus.img_mounted = 4'b0;
    bus.img_size_nz = 1'b0; bus.img_readonly = 1'b0; bus.sd_ack = 4'b0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_protection();
    test_rd_wr_same();
    test_reset_mid();
`ifdef SD_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
